// File: rtl/data_memory_hs.sv
// Byte-addressed data memory with a valid/ready request port and a fixed,
// configurable access latency. Define DMEM_ALIGN_CHECK_EN to fault misaligned
// requests; without it only out-of-range requests fault.
//
// Ports:
//   clock, reset            : single clock, async active-high reset
//   req_valid / req_ready   : request handshake (ready only while idle)
//   req_write               : 1 = write, 0 = read
//   req_addr                : byte address of the lowest byte of the word
//   req_wdata / req_be      : little-endian write data and lane enables
//   resp_valid              : one-cycle completion pulse
//   resp_rdata / resp_error : read data and fault flag, valid with resp_valid
module data_memory_hs #(
  parameter int DATA_BYTES  = 8,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  input  logic [DATA_BYTES-1:0]   req_be,
  output logic                    resp_valid,
  output logic [8*DATA_BYTES-1:0] resp_rdata,
  output logic                    resp_error
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int IW  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int AW1 = ADDR_W + 1;

  // End-of-access address is formed one bit wider so it cannot wrap.
  localparam logic [AW1-1:0] LIMIT = AW1'(DEPTH_BYTES);
  localparam logic [AW1-1:0] SPAN  = AW1'(DATA_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]        count;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DW-1:0]     lat_wdata;
  logic [DATA_BYTES-1:0] lat_be;

  logic          accept;
  logic          access;
  logic          fault;
  logic          bound_fault;
  logic          mem_we;
  logic [AW1-1:0] end_addr;
  logic [IW-1:0]  base;
  logic [DW-1:0]  rd_word;

  logic [7:0] mem [DEPTH_BYTES];

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign resp_valid = (state == RESP);

  assign end_addr    = {1'b0, lat_addr} + SPAN;
  assign bound_fault = (end_addr > LIMIT);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(DATA_BYTES - 1);
  assign fault = bound_fault | ((lat_addr & LANE_MASK) != '0);
`else
  assign fault = bound_fault;
`endif

  assign base = lat_addr[IW-1:0];

  // Gathered read word; only consumed when the access is in range.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_word[8*i +: 8] = mem[base + IW'(i)];
    end
  end

  // A reset present on the access edge must suppress the write as well.
  assign mem_we = access & lat_write & ~fault & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        count     <= 4'(WAIT_CYCLES);
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (access) begin
        resp_error <= fault;
        resp_rdata <= (fault | lat_write) ? '0 : rd_word;
      end else if (state == RESP) begin
        resp_error <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (lat_be[i]) begin
          mem[base + IW'(i)] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed vector table, randomized traffic
// against a byte-array model, and a reset-abort case at WAIT_CYCLES=3.
module tb_data_memory_hs;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;

  logic        rst3;
  logic        r3_valid;
  logic        r3_ready;
  logic        r3_write;
  logic [63:0] r3_addr;
  logic [63:0] r3_wdata;
  logic [7:0]  r3_be;
  logic        r3_rvalid;
  logic [63:0] r3_rdata;
  logic        r3_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [1024];

  data_memory_hs dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  data_memory_hs #(.WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(rst3),
    .req_valid(r3_valid), .req_ready(r3_ready),
    .req_write(r3_write), .req_addr(r3_addr),
    .req_wdata(r3_wdata), .req_be(r3_be),
    .resp_valid(r3_rvalid), .resp_rdata(r3_rdata),
    .resp_error(r3_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic m_fault(input logic [63:0] a);
    logic [64:0] e;
    e = {1'b0, a} + 65'd8;
    return (e > 65'd1024) || (ALIGN && (a[2:0] != 3'd0));
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[int'(a) + i];
    return w;
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] be);
    for (int i = 0; i < 8; i++)
      if (be[i]) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  time acc_time;

  task automatic do_req(input logic wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] be,
                        input bit chk_pulse,
                        output logic [63:0] rd, output logic err,
                        output int lat, output logic pulse_ok);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    acc_time = $time;
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_be    = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!resp_valid && lat < 40);
    rd = resp_rdata;
    err = resp_error;
    pulse_ok = 1'b1;
    if (chk_pulse) begin
      @(posedge clock);
      #1;
      pulse_ok = !resp_valid;
    end
  endtask

  task automatic do_req3(input logic wr, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd);
    int n;
    @(negedge clock);
    r3_valid = 1'b1;
    r3_write = wr;
    r3_addr  = a;
    r3_wdata = wd;
    r3_be    = 8'hFF;
    n = 0;
    while (!r3_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    r3_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!r3_rvalid && n < 40);
    chk("w3_latency", 64'(n), 64'd4);
    rd = r3_rdata;
  endtask

  initial begin
    logic [63:0] rd;
    logic        err;
    int          lat;
    logic        pok;
    time         t1;
    int          seen;

    reset = 1'b1;
    rst3 = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0;
    r3_valid = 1'b0; r3_write = 1'b0; r3_addr = '0;
    r3_wdata = '0; r3_be = '0;

    #3;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_error", 64'(resp_error), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);

    vecs[0]  = '{1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'h10, 64'h0, 8'hFF, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[4]  = '{1'b1, 64'h18, 64'h0807060504030201, 8'hFF, 64'h0, 1'b0};
    vecs[5]  = '{1'b0, 64'h13, 64'h0, 8'hFF,
                 ALIGN ? 64'h0 : 64'h03020111223344AA, ALIGN};
    vecs[6]  = '{1'b1, 64'h3F8, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0};
    vecs[7]  = '{1'b1, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    vecs[8]  = '{1'b0, 64'h3F9, 64'h0, 8'hFF, 64'h0, 1'b1};
    vecs[9]  = '{1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555555555555555, 8'hFF,
                 64'h0, 1'b1};
    vecs[10] = '{1'b0, 64'h3F8, 64'h0, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0};
    vecs[11] = '{1'b0, 64'h0, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 1'b0};
    vecs[12] = '{1'b1, 64'h3FC, 64'h6666666666666666, 8'hFF, 64'h0, 1'b1};
    vecs[13] = '{1'b0, 64'h3F8, 64'h0, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0};

    foreach (vecs[k]) begin
      do_req(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].be, 1'b1,
             rd, err, lat, pok);
      chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
      chk($sformatf("vec%0d_error", k), 64'(err), 64'(vecs[k].exp_err));
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_pulse", k), 64'(pok), 64'd1);
    end

    do_req(1'b0, 64'h10, 64'h0, 8'hFF, 1'b0, rd, err, lat, pok);
    t1 = acc_time;
    do_req(1'b0, 64'h10, 64'h0, 8'hFF, 1'b0, rd, err, lat, pok);
    chk("accept_spacing", 64'((acc_time - t1) / 10), 64'd4);
    chk("b2b_rdata", rd, 64'h11223344AAAAAAAA);

    for (int a = 0; a < 1024; a += 8) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      m_write(64'(a), d, 8'hFF);
      do_req(1'b1, 64'(a), d, 8'hFF, 1'b0, rd, err, lat, pok);
    end

    for (int k = 0; k < 300; k++) begin
      logic        wr;
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  be;
      logic        e_err;
      logic [63:0] e_rd;
      wr = 1'($urandom_range(0, 1));
      a  = 64'($urandom_range(0, 1040));
      if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      be = 8'($urandom);
      e_err = m_fault(a);
      e_rd  = (e_err || wr) ? 64'h0 : m_read(a);
      if (!e_err && wr) m_write(a, d, be);
      do_req(wr, a, d, be, 1'b0, rd, err, lat, pok);
      chk($sformatf("rnd%0d_rdata", k), rd, e_rd);
      chk($sformatf("rnd%0d_error", k), 64'(err), 64'(e_err));
      chk($sformatf("rnd%0d_latency", k), 64'(lat), 64'd2);
    end

    do_req3(1'b1, 64'h40, 64'hCAFEBABE12345678, rd);
    @(negedge clock);
    r3_valid = 1'b1;
    r3_write = 1'b1;
    r3_addr  = 64'h40;
    r3_wdata = 64'h0BADF00D0BADF00D;
    r3_be    = 8'hFF;
    @(posedge clock);
    #1;
    r3_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    rst3 = 1'b1;
    #1;
    chk("abort_ready_now", 64'(r3_ready), 64'd1);
    chk("abort_rvalid_now", 64'(r3_rvalid), 64'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (r3_rvalid) seen++;
    end
    @(negedge clock);
    rst3 = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (r3_rvalid) seen++;
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    chk("abort_ready_after", 64'(r3_ready), 64'd1);
    do_req3(1'b0, 64'h40, 64'h0, rd);
    chk("abort_old_data", rd, 64'hCAFEBABE12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
